secuenciador_edicion: RTL and testbench
=======================================

SECUENCIADOR_EDICION -- requirements
Module: secuenciador_edicion

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-002 Keypad inputs SHALL be:
- key_valid  in  1  one-cycle strobe; key_code is valid when this is high.
- key_code  in  4  0x0-0x9 digit, 0xA ALARM, 0xB TIME, 0xC ENTER, 0xD CANCEL; 0xE-0xF ignored.
REQ-003 Timing input SHALL be tick_1hz  in  1, a one-cycle strobe once per second.
REQ-004 Register-bank write outputs SHALL be:
- habiha  out  1  one-cycle write strobe to the alarm register.
- habihm  out  1  one-cycle write strobe to the time register.
- wr_hh  out  8  BCD hours {tens,units}; held stable while either strobe is high.
- wr_mm  out  8  BCD minutes; held stable while either strobe is high.
REQ-005 Status outputs SHALL be:
- busy  out  1  high in every state except IDLE.
- digit_pos  out  2  index of the next digit to enter (0 = hour tens ... 3 = minute units).
- err  out  1  one-cycle strobe on rejected digit or incomplete ENTER.

Function
REQ-006 The FSM SHALL have states IDLE, ENTRY, COMMIT; target flag tgt (0 = time, 1 = alarm) and digit counter digit_pos 0-4.
REQ-007 IDLE transitions SHALL be:
- ALARM key: tgt=1, digit_pos=0, wr_hh=wr_mm=0x00, go to ENTRY.
- TIME key: same, with tgt=0.
- Any other key: ignored.
REQ-008 In ENTRY, a digit SHALL be accepted only if within its position limit:
- pos0 ≤ 2.
- pos1 ≤ 9 (≤ 3 when hour tens = 2).
- pos2 ≤ 5.
- pos3 ≤ 9.
REQ-009 On acceptance, the digit SHALL be written into its nibble and digit_pos SHALL increment, saturating at 4.
REQ-010 A rejected digit, or a digit at pos 4, SHALL assert err for one cycle and leave all state unchanged.
REQ-011 ENTER in ENTRY with digit_pos = 4 SHALL go to COMMIT; with digit_pos < 4 it SHALL pulse err and stay in ENTRY.
REQ-012 CANCEL in ENTRY SHALL return to IDLE with no write strobe.
REQ-013 ALARM/TIME keys in ENTRY SHALL retarget tgt and restart at digit_pos = 0 with cleared digits.
REQ-014 COMMIT SHALL last exactly one cycle and then return to IDLE:
- habiha = tgt, habihm = ~tgt.
- Keys arriving during COMMIT are ignored.
REQ-015 Latency from the ENTER strobe edge to the write strobe SHALL be exactly 1 clock.
REQ-016 habiha and habihm SHALL never be high in the same cycle, and SHALL never be high outside COMMIT.
REQ-017 All outputs SHALL be registered.
REQ-018 wr_hh and wr_mm SHALL hold their values after COMMIT until the next ALARM/TIME key.

Reset
REQ-019 Reset SHALL force the following on the next rising edge, overriding any key or tick in the same cycle, including mid-entry and during COMMIT:
- state = IDLE, tgt = 0, digit_pos = 0.
- wr_hh = wr_mm = 0x00.
- habiha = habihm = err = busy = 0.
- Timeout counter = 0.

Configuration
REQ-020 With macro SECUENCIADOR_TIMEOUT_EN defined, the block SHALL include a 4-bit timeout counter:
- Counter clears on entering ENTRY and on every accepted or rejected key.
- Counter increments on tick_1hz while in ENTRY.
- At a count of 10, the block returns to IDLE with no write and no err.
- When key_valid and tick_1hz coincide, the key wins and the counter clears.
REQ-021 Without SECUENCIADOR_TIMEOUT_EN, the block SHALL omit the counter, ignore tick_1hz, and remain in ENTRY indefinitely.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- TIME, 1, 2, 3, 4, ENTER -> one cycle later habihm=1 for 1 cycle, wr_hh=0x12, wr_mm=0x34, habiha=0 throughout.
- ALARM, 2, 4 -> err pulse on '4' (hour 24 rejected), digit_pos stays 1; then 3, 5, 9, ENTER -> habiha pulse, wr_hh=0x23, wr_mm=0x59.
- TIME, 0, 7, ENTER -> err pulse, busy stays 1; CANCEL -> busy=0, no strobe.
- TIME, 1, reset asserted mid-entry, then ENTER -> all outputs 0, state IDLE, no strobe.
- With SECUENCIADOR_TIMEOUT_EN: ALARM, 10 tick_1hz pulses, no keys -> busy falls after the 10th tick, no strobe; a key on the same cycle as tick 9 restarts the count.
- Without SECUENCIADOR_TIMEOUT_EN: ALARM, 20 ticks -> busy stays 1.

Source files
------------

// File: rtl/secuenciador_edicion.sv
// Keypad-driven time/alarm editor: collects four BCD digits and pulses a write strobe on ENTER.
// Optional inactivity timeout enabled by defining SECUENCIADOR_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for ALARM or TIME key
// ENTRY  | collecting hh:mm digits for the selected target
// COMMIT | one-cycle write strobe to the alarm or time register
module secuenciador_edicion (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       tick_1hz,
   output logic       habiha,
   output logic       habihm,
   output logic [7:0] wr_hh,
   output logic [7:0] wr_mm,
   output logic       busy,
   output logic [1:0] digit_pos,
   output logic       err
);

   typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_COMMIT} state_t;

   localparam logic [3:0] K_ALARM  = 4'hA;
   localparam logic [3:0] K_TIME   = 4'hB;
   localparam logic [3:0] K_ENTER  = 4'hC;
   localparam logic [3:0] K_CANCEL = 4'hD;

   state_t     state_q, state_d;
   logic       tgt_q, tgt_d;
   logic [2:0] pos_q, pos_d;
   logic [7:0] hh_q, hh_d, mm_q, mm_d;
   logic       err_q, err_d;
   logic       habiha_q, habiha_d, habihm_q, habihm_d;
   logic       busy_q, busy_d;
   logic [1:0] dpos_q, dpos_d;
   logic       digit_ok;
   logic       timeout;

`ifdef SECUENCIADOR_TIMEOUT_EN
   logic [3:0] cnt_q, cnt_d;

   // Reaching a count of ten means this tick is the tenth since the last key.
   assign timeout = (state_q == S_ENTRY) && !key_valid && tick_1hz && (cnt_q == 4'd9);

   always_comb begin
      cnt_d = 4'd0;
      if (state_d == S_ENTRY && state_q == S_ENTRY && !key_valid && tick_1hz)
         cnt_d = cnt_q + 4'd1;
      else if (state_d == S_ENTRY && state_q == S_ENTRY && !key_valid)
         cnt_d = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 4'd0;
      else       cnt_q <= cnt_d;
   end
`else
   logic unused_tick;
   assign unused_tick = tick_1hz;
   assign timeout     = 1'b0;
`endif

   always_comb begin
      digit_ok = 1'b0;
      case (pos_q)
         3'd0:    digit_ok = (key_code <= 4'd2);
         3'd1:    digit_ok = (hh_q[7:4] == 4'd2) ? (key_code <= 4'd3) : (key_code <= 4'd9);
         3'd2:    digit_ok = (key_code <= 4'd5);
         3'd3:    digit_ok = (key_code <= 4'd9);
         default: digit_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      pos_d   = pos_q;
      hh_d    = hh_q;
      mm_d    = mm_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (key_valid && (key_code == K_ALARM || key_code == K_TIME)) begin
               tgt_d   = (key_code == K_ALARM);
               pos_d   = 3'd0;
               hh_d    = 8'h00;
               mm_d    = 8'h00;
               state_d = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (key_valid) begin
               if (key_code <= 4'd9) begin
                  if (digit_ok) begin
                     case (pos_q)
                        3'd0:    hh_d[7:4] = key_code;
                        3'd1:    hh_d[3:0] = key_code;
                        3'd2:    mm_d[7:4] = key_code;
                        default: mm_d[3:0] = key_code;
                     endcase
                     pos_d = pos_q + 3'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (key_code == K_ALARM || key_code == K_TIME) begin
                  tgt_d = (key_code == K_ALARM);
                  pos_d = 3'd0;
                  hh_d  = 8'h00;
                  mm_d  = 8'h00;
               end else if (key_code == K_ENTER) begin
                  if (pos_q == 3'd4) state_d = S_COMMIT;
                  else               err_d   = 1'b1;
               end else if (key_code == K_CANCEL) begin
                  state_d = S_IDLE;
               end
            end else if (timeout) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      habiha_d = (state_d == S_COMMIT) && tgt_d;
      habihm_d = (state_d == S_COMMIT) && !tgt_d;
      busy_d   = (state_d != S_IDLE);
      dpos_d   = (pos_d >= 3'd3) ? 2'd3 : pos_d[1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tgt_q    <= 1'b0;
         pos_q    <= 3'd0;
         hh_q     <= 8'h00;
         mm_q     <= 8'h00;
         err_q    <= 1'b0;
         habiha_q <= 1'b0;
         habihm_q <= 1'b0;
         busy_q   <= 1'b0;
         dpos_q   <= 2'd0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         pos_q    <= pos_d;
         hh_q     <= hh_d;
         mm_q     <= mm_d;
         err_q    <= err_d;
         habiha_q <= habiha_d;
         habihm_q <= habihm_d;
         busy_q   <= busy_d;
         dpos_q   <= dpos_d;
      end
   end

   assign habiha    = habiha_q;
   assign habihm    = habihm_q;
   assign wr_hh     = hh_q;
   assign wr_mm     = mm_q;
   assign busy      = busy_q;
   assign digit_pos = dpos_q;
   assign err       = err_q;

endmodule

// File: tb/tb_secuenciador_edicion.sv
// Directed and random checks of secuenciador_edicion against a digit-list reference model.
module tb_secuenciador_edicion;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       tick_1hz = 1'b0;
   logic       habiha, habihm, busy, err;
   logic [7:0] wr_hh, wr_mm;
   logic [1:0] digit_pos;

   int total = 0;
   int bad   = 0;

   // reference model: mode 0=idle 1=entry 2=commit
   int m_mode = 0;
   int m_tgt  = 0;
   int m_n    = 0;
   int m_dig [4] = '{0, 0, 0, 0};
   int m_secs = 0;
   int m_err  = 0;

   secuenciador_edicion dut (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
      .tick_1hz(tick_1hz), .habiha(habiha), .habihm(habihm), .wr_hh(wr_hh),
      .wr_mm(wr_mm), .busy(busy), .digit_pos(digit_pos), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int limit_for(input int n);
      if (n == 0) return 2;
      if (n == 1) return (m_dig[0] == 2) ? 3 : 9;
      if (n == 2) return 5;
      return 9;
   endfunction

   task automatic model_step(input bit rst, input bit kv, input int code, input bit tk);
      m_err = 0;
      if (rst) begin
         m_mode = 0; m_tgt = 0; m_n = 0; m_secs = 0;
         m_dig = '{0, 0, 0, 0};
      end else if (m_mode == 2) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (kv && (code == 10 || code == 11)) begin
            m_mode = 1; m_tgt = (code == 10); m_n = 0; m_secs = 0;
            m_dig = '{0, 0, 0, 0};
         end
      end else begin
         if (kv) begin
            m_secs = 0;
            if (code <= 9) begin
               if (m_n < 4 && code <= limit_for(m_n)) begin
                  m_dig[m_n] = code;
                  m_n++;
               end else m_err = 1;
            end else if (code == 10 || code == 11) begin
               m_tgt = (code == 10); m_n = 0; m_dig = '{0, 0, 0, 0};
            end else if (code == 12) begin
               if (m_n == 4) m_mode = 2; else m_err = 1;
            end else if (code == 13) begin
               m_mode = 0;
            end
         end else if (tk) begin
`ifdef SECUENCIADOR_TIMEOUT_EN
            m_secs++;
            if (m_secs == 10) m_mode = 0;
`endif
         end
      end
   endtask

   task automatic cycle(input bit rst, input bit kv, input int code, input bit tk);
      reset     = rst;
      key_valid = kv;
      key_code  = 4'(code);
      tick_1hz  = tk;
      @(posedge clk);
      model_step(rst, kv, code, tk);
      #1;
      check("busy",      32'(busy),      32'(m_mode != 0));
      check("err",       32'(err),       32'(m_err));
      check("habiha",    32'(habiha),    32'(m_mode == 2 && m_tgt == 1));
      check("habihm",    32'(habihm),    32'(m_mode == 2 && m_tgt == 0));
      check("digit_pos", 32'(digit_pos), 32'((m_n > 3) ? 3 : m_n));
      check("wr_hh",     32'(wr_hh),     32'(m_dig[0] * 16 + m_dig[1]));
      check("wr_mm",     32'(wr_mm),     32'(m_dig[2] * 16 + m_dig[3]));
      reset = 1'b0; key_valid = 1'b0; tick_1hz = 1'b0;
   endtask

   task automatic key(input int code);
      cycle(0, 1, code, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   initial begin
      #2;
      cycle(1, 0, 0, 0);
      cycle(1, 1, 11, 1);
      check("rst_busy", 32'(busy), 32'd0);
      idle(2);

      // TIME 1 2 3 4 ENTER
      key(11); key(1); key(2); key(3); key(4);
      check("t1_pos_full", 32'(digit_pos), 32'd3);
      key(12);
      check("t1_habihm", 32'(habihm), 32'd1);
      check("t1_habiha", 32'(habiha), 32'd0);
      check("t1_hh", 32'(wr_hh), 32'h12);
      check("t1_mm", 32'(wr_mm), 32'h34);
      idle(1);
      check("t1_strobe_end", 32'(habihm), 32'd0);
      check("t1_hold_hh", 32'(wr_hh), 32'h12);
      idle(1);

      // ALARM 2 4(rejected) 3 5 9 ENTER
      key(10); key(2); key(4);
      check("t2_err", 32'(err), 32'd1);
      check("t2_pos", 32'(digit_pos), 32'd1);
      key(3); key(5); key(9);
      key(5);
      check("t2_err_pos4", 32'(err), 32'd1);
      key(12);
      check("t2_habiha", 32'(habiha), 32'd1);
      check("t2_hh", 32'(wr_hh), 32'h23);
      check("t2_mm", 32'(wr_mm), 32'h59);
      key(11);
      check("t2_commit_ignores", 32'(busy), 32'd0);
      idle(1);

      // TIME 0 7 ENTER(incomplete) CANCEL
      key(11); key(0); key(7); key(12);
      check("t3_err", 32'(err), 32'd1);
      check("t3_busy", 32'(busy), 32'd1);
      key(13);
      check("t3_cancel", 32'(busy), 32'd0);
      idle(1);

      // TIME 1, reset mid-entry, ENTER
      key(11); key(1);
      cycle(1, 0, 0, 0);
      key(12);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_hh", 32'(wr_hh), 32'h00);
      idle(1);

`ifdef SECUENCIADOR_TIMEOUT_EN
      key(10);
      for (int i = 0; i < 9; i++) cycle(0, 0, 0, 1);
      check("to_busy9", 32'(busy), 32'd1);
      cycle(0, 0, 0, 1);
      check("to_expire", 32'(busy), 32'd0);
      check("to_no_err", 32'(err), 32'd0);
      key(10);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);
      cycle(0, 1, 1, 1);
      for (int i = 0; i < 9; i++) cycle(0, 0, 0, 1);
      check("to_restart", 32'(busy), 32'd1);
      cycle(0, 0, 0, 1);
      check("to_restart_expire", 32'(busy), 32'd0);
`else
      key(10);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1);
      check("no_timeout", 32'(busy), 32'd1);
      key(13);
`endif

      for (int i = 0; i < 4000; i++) begin
         automatic bit rst = ($urandom_range(0, 299) == 0);
         automatic bit kv  = ($urandom_range(0, 2) == 0);
         automatic int cd  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9)
                                                         : $urandom_range(10, 15);
         automatic bit tk  = ($urandom_range(0, 2) == 0);
         cycle(rst, kv, cd, tk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
